mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch and data request streams leaving the request unit.
- Selects one requester per transaction and holds the latched address/data on the RAM port until RAM reports ACCESS, then completes back to that requester.
- Grants data before instruction, with a bounded-starvation guarantee for fetch; adds a RAM timeout/error path.
- Sits between the request unit outputs and the RAM model, inside the datapath top level.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while iREN is pending before a fetch is forced.
- TIMEOUT, 255: cycles in a grant state without ACCESS before the transaction is aborted.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address.
- iload  out  32  instruction read data.
- iwait  out  1  instruction stall.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dload  out  32  data read data.
- dwait  out  1  data stall.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- mem_err  out  1  sticky error flag.

Behaviour:
- States: IDLE, IGRANT, DREAD, DWRITE.
- IDLE:
  - Data request pending (dWEN or dREN) and (starve_cnt < STARVE_MAX or iREN=0): go to DWRITE if dWEN, else DREAD. dWEN wins when both dREN and dWEN are high.
  - Otherwise iREN pending: go to IGRANT.
  - On any grant, latch address (and dstore for writes) into txn registers.
- Grant states:
  - ramREN or ramWEN and ramaddr/ramstore are driven from the txn registers only. Later requester input changes, including a dropped request, are ignored; the transaction always completes.
  - Each cycle with ramstate != ACCESS increments tmo_cnt (8 bits minimum, width clog2(TIMEOUT+1)).
  - Completion when ramstate == ACCESS: the owner's wait is 0 for exactly this cycle; iload/dload = ramload combinationally; next state IDLE.
  - Abort when ramstate == ERROR or tmo_cnt == TIMEOUT: mem_err set (sticky until RST); the owner's wait is 0 that cycle with load = 32'h0; next state IDLE.
- Wait signals:
  - iwait = iREN & ~(IGRANT & done).
  - dwait = (dREN | dWEN) & ~((DREAD | DWRITE) & done).
  - done is the completion or abort condition.
  - A request is therefore stalled in IDLE and for the whole grant.
- Latency: minimum 2 cycles from request to wait low (IDLE decision plus one ACCESS cycle). A completed requester is not re-granted until the cycle after IDLE.
- starve_cnt:
  - Increments on each data grant made while iREN=1.
  - Clears on an IGRANT grant or whenever iREN=0 in IDLE.
  - Saturates at STARVE_MAX.
- tmo_cnt clears on entry to every grant state.
- Outside grant states: ramREN = ramWEN = 0, ramaddr = 0, ramstore = 0.
- iload/dload: 0 except in the owner's done cycle.
- Reset (RST high at a clock edge, including mid-transaction):
  - state = IDLE; all counters and txn registers = 0; mem_err = 0.
  - Outputs return to the idle values above on the following cycle.
  - No completion is signalled for the aborted transaction.

Decomposition:
- cpu_types_pkg: ramstate_t and word_t are already present; add arb_state_t (IDLE, IGRANT, DREAD, DWRITE).
- STARVE_MAX and TIMEOUT stay module parameters.
- Interface: mem_arbiter_if with modport arb, following the existing interface style.
- No sub-module is needed. The priority/starvation pick is a single always_comb block.

Test Plan:
- Single fetch: iREN=1, iaddr=32'h40; RAM returns ACCESS on the 3rd grant cycle with ramload=32'h2402000A → ramREN=1, ramaddr=32'h40 for 3 cycles; iwait=0 and iload=32'h2402000A only in the ACCESS cycle; returns to IDLE.
- Simultaneous requests: iREN=1 and dREN=1, daddr=32'h80, both held → DREAD served first (ramaddr=32'h80), IGRANT follows after one IDLE cycle.
- Starvation limit: iREN held; dREN reasserted immediately after each completion, RAM 1-cycle ACCESS → exactly 4 data grants, then IGRANT; starve_cnt returns to 0.
- Write precedence: dREN=1, dWEN=1, daddr=32'hFC, dstore=32'hDEADBEEF → ramWEN=1, ramREN=0, ramstore=32'hDEADBEEF.
- Timeout: ramstate held BUSY → abort on the cycle tmo_cnt==255; dwait=0 with dload=0 that cycle; mem_err=1 and stays 1 until RST.
- Reset mid-grant: RST pulsed in the 2nd DWRITE cycle → ramWEN=0 on the next cycle, no dwait drop, state IDLE, mem_err=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word size, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle between the request unit, the memory arbiter and the RAM model.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  // request unit side
  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;
  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      mem_err;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data before fetch, bounded fetch starvation,
// transaction held on the RAM port until ACCESS, ERROR or timeout.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        RST,
  mem_arbiter_if.arb  bus
);

  localparam int TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);
  localparam logic [STV_W-1:0] STV_LIM = STV_W'(STARVE_MAX);

  arb_state_t       state, next_state, pick_state;
  logic [STV_W-1:0] starve_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  word_t            txn_addr;
  word_t            txn_data;
  logic             mem_err_q;

  logic granted, access, abort, done;

  // Priority pick: data wins unless fetch has been passed over STARVE_MAX times.
  always_comb begin
    pick_state = IDLE;
    if ((bus.dREN || bus.dWEN) && ((starve_cnt < STV_LIM) || !bus.iREN))
      pick_state = bus.dWEN ? DWRITE : DREAD;
    else if (bus.iREN)
      pick_state = IGRANT;
  end

  assign granted = (state != IDLE);
  assign access  = granted && (bus.ramstate == ACCESS);
  assign abort   = granted && !access &&
                   ((bus.ramstate == ERROR) || (tmo_cnt == TMO_LIM));
  assign done    = access || abort;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.iwait    = bus.iREN;
    bus.dwait    = bus.dREN || bus.dWEN;
    bus.mem_err  = mem_err_q;
    case (state)
      IDLE: next_state = pick_state;
      IGRANT, DREAD, DWRITE: begin
        bus.ramREN   = (state != DWRITE);
        bus.ramWEN   = (state == DWRITE);
        bus.ramaddr  = txn_addr;
        bus.ramstore = txn_data;
        if (done) begin
          next_state = IDLE;
          if (state == IGRANT) begin
            bus.iwait = 1'b0;
            bus.iload = access ? bus.ramload : '0;
          end else begin
            bus.dwait = 1'b0;
            bus.dload = access ? bus.ramload : '0;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Transaction registers and counters; txn_data stays zero for reads so
  // ramstore only ever carries write data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      txn_addr   <= '0;
      txn_data   <= '0;
      mem_err_q  <= 1'b0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
      if (pick_state != IDLE) begin
        txn_addr <= (pick_state == IGRANT) ? bus.iaddr : bus.daddr;
        txn_data <= (pick_state == DWRITE) ? bus.dstore : '0;
      end
      if (!bus.iREN || (pick_state == IGRANT))
        starve_cnt <= '0;
      else if ((pick_state != IDLE) && (starve_cnt != STV_LIM))
        starve_cnt <= starve_cnt + 1'b1;
    end else begin
      if (!done)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (abort)
        mem_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 255;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: who owns the RAM (0 none, 1 fetch, 2 data read, 3 data write),
  // what it latched, how long it has waited, and how often fetch was skipped.
  int    m_owner, m_age, m_skips;
  word_t m_addr, m_data;
  bit    m_err;
  bit    chk_en;

  // Observation counters used by the directed scenarios.
  int obs_dfin, obs_ifin, obs_grant_cycles;

  task automatic set_in(input bit ir, input word_t ia, input bit dr, input bit dw,
                        input word_t da, input word_t ds, input ramstate_t rs, input word_t rl);
    bus.iREN = ir; bus.iaddr = ia; bus.dREN = dr; bus.dWEN = dw;
    bus.daddr = da; bus.dstore = ds; bus.ramstate = rs; bus.ramload = rl;
  endtask

  task automatic tick();
    bit granted, acc, ab, fin, dreq;
    @(negedge CLK);
    granted = (m_owner != 0);
    acc     = granted && (bus.ramstate == ACCESS);
    ab      = granted && !acc && ((bus.ramstate == ERROR) || (m_age == TIMEOUT));
    fin     = acc || ab;
    dreq    = bus.dREN || bus.dWEN;
    if (bus.ramREN || bus.ramWEN) obs_grant_cycles++;
    if (dreq && !bus.dwait) obs_dfin++;
    if (bus.iREN && !bus.iwait) obs_ifin++;
    if (chk_en) begin
      check_val("ramREN",   32'(bus.ramREN),  32'(m_owner == 1 || m_owner == 2));
      check_val("ramWEN",   32'(bus.ramWEN),  32'(m_owner == 3));
      check_val("ramaddr",  bus.ramaddr,      granted ? m_addr : 32'h0);
      check_val("ramstore", bus.ramstore,     (m_owner == 3) ? m_data : 32'h0);
      check_val("iwait",    32'(bus.iwait),   32'(bus.iREN && !(m_owner == 1 && fin)));
      check_val("dwait",    32'(bus.dwait),   32'(dreq && !(m_owner >= 2 && fin)));
      check_val("iload",    bus.iload,        (m_owner == 1 && acc) ? bus.ramload : 32'h0);
      check_val("dload",    bus.dload,        (m_owner >= 2 && acc) ? bus.ramload : 32'h0);
      check_val("mem_err",  32'(bus.mem_err), 32'(m_err));
      check_val("starve_cnt", 32'(dut.starve_cnt), 32'(m_skips));
    end
    // advance the model to what the next clock edge produces
    if (RST) begin
      m_owner = 0; m_age = 0; m_skips = 0; m_err = 0; m_addr = 0; m_data = 0;
    end else if (granted) begin
      if (fin) begin
        m_err   = m_err | ab;
        m_owner = 0;
      end else begin
        m_age++;
      end
    end else if (dreq && (m_skips < STARVE_MAX || !bus.iREN)) begin
      m_owner = bus.dWEN ? 3 : 2;
      m_addr  = bus.daddr;
      m_data  = bus.dWEN ? bus.dstore : 32'h0;
      m_age   = 0;
      m_skips = bus.iREN ? m_skips + 1 : 0;
    end else if (bus.iREN) begin
      m_owner = 1; m_addr = bus.iaddr; m_data = 0; m_age = 0; m_skips = 0;
    end else begin
      m_skips = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet(input int n);
    for (int k = 0; k < n; k++) begin
      set_in(0, 0, 0, 0, 0, 0, FREE, 0);
      tick();
    end
  endtask

  function automatic ramstate_t pick_rs(input bit granted);
    int r;
    r = int'($urandom_range(0, 19));
    if (!granted) return ramstate_t'($urandom_range(0, 3));
    if (r < 8)  return ACCESS;
    if (r < 17) return BUSY;
    if (r < 19) return FREE;
    return ERROR;
  endfunction

  initial begin
    chk_en = 0;
    m_owner = 0; m_age = 0; m_skips = 0; m_err = 0; m_addr = 0; m_data = 0;
    obs_dfin = 0; obs_ifin = 0; obs_grant_cycles = 0;
    RST = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, FREE, 0);
    @(posedge CLK); #1;
    tick();
    chk_en = 1;
    tick();
    RST = 1'b0;
    quiet(2);

    // Single fetch with ACCESS on the third grant cycle.
    obs_grant_cycles = 0; obs_ifin = 0;
    set_in(1, 32'h40, 0, 0, 0, 0, FREE, 0);  tick();
    set_in(1, 32'h40, 0, 0, 0, 0, BUSY, 0);  tick(); tick();
    set_in(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h2402000A); tick();
    set_in(0, 0, 0, 0, 0, 0, FREE, 0); tick();
    check_val("fetch_grant_cycles", 32'(obs_grant_cycles), 32'd3);
    check_val("fetch_done_count", 32'(obs_ifin), 32'd1);
    quiet(1);

    // Simultaneous requests: data first, then fetch after an IDLE cycle.
    obs_dfin = 0; obs_ifin = 0;
    set_in(1, 32'h40, 1, 0, 32'h80, 0, FREE, 0); tick();
    set_in(1, 32'h40, 1, 0, 32'h80, 0, ACCESS, 32'h11112222); tick();
    set_in(1, 32'h40, 0, 0, 0, 0, FREE, 0); tick();
    set_in(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h33334444); tick();
    check_val("simul_data_done", 32'(obs_dfin), 32'd1);
    check_val("simul_fetch_done", 32'(obs_ifin), 32'd1);
    quiet(1);

    // Starvation: data always pending, 1-cycle ACCESS; fetch forced after 4.
    obs_dfin = 0; obs_ifin = 0;
    for (int k = 0; k < 30 && obs_ifin == 0; k++) begin
      set_in(1, 32'h44, 1, 0, 32'h80, 0, (m_owner != 0) ? ACCESS : FREE, $urandom);
      tick();
    end
    check_val("starve_data_grants", 32'(obs_dfin), 32'(STARVE_MAX));
    check_val("starve_fetch_done", 32'(obs_ifin), 32'd1);
    quiet(1);

    // Timeout: RAM stays BUSY; abort after TIMEOUT+1 grant cycles.
    obs_grant_cycles = 0; obs_dfin = 0;
    set_in(0, 0, 1, 0, 32'h90, 0, FREE, 0); tick();
    for (int k = 0; k < 300 && obs_dfin == 0; k++) begin
      set_in(0, 0, 1, 0, 32'h90, 0, BUSY, 32'hFFFFFFFF);
      tick();
    end
    check_val("tmo_grant_cycles", 32'(obs_grant_cycles), 32'(TIMEOUT + 1));
    check_val("tmo_abort_seen", 32'(obs_dfin), 32'd1);
    quiet(3);

    // Write precedence, then reset in the second DWRITE cycle.
    set_in(0, 0, 1, 1, 32'hFC, 32'hDEADBEEF, FREE, 0); tick();
    set_in(0, 0, 1, 1, 32'hFC, 32'hDEADBEEF, BUSY, 0); tick();
    RST = 1'b1; tick();
    RST = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, ACCESS, 32'h5A5A5A5A); tick();
    quiet(2);

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      RST = ($urandom_range(0, 299) == 0);
      set_in($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, $urandom, $urandom,
             pick_rs(m_owner != 0), $urandom);
      tick();
    end
    RST = 1'b0;
    quiet(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
